// File: rtl/tid_inorder_mc_pkg.sv
// Shared helpers for the in-order release buffer and its arbiter.
package tid_inorder_pkg;

    localparam int FIFO_DEPTH = 2;

    // Index width that stays legal (>= 1 bit) for single-entry sets.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: searches from the rotating pointer, which moves past the winner when adv is set.
module rr_arb
    import tid_inorder_pkg::*;
#(
    parameter int N   = 4,
    parameter int N_L = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           adv,
    output logic [N-1:0]   gnt,
    output logic [N_L-1:0] gnt_idx,
    output logic           gnt_v
);

    logic [N_L-1:0] ptr;

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_v   = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!gnt_v && req[j]) begin
                gnt_v   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = N_L'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv && gnt_v) begin
            ptr <= (gnt_idx == N_L'(N - 1)) ? '0 : gnt_idx + N_L'(1);
        end
    end

endmodule

// File: rtl/simple_dual_port_ram.sv
// One write port, one registered read port; read_first returns the pre-write word on a same-address collision.
module simple_dual_port_ram #(
    parameter int    DW    = 32,
    parameter int    DEPTH = 64,
    parameter int    AW    = $clog2(DEPTH),
    parameter string MODE  = "read_first"
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    generate
        if (MODE == "write_first") begin : g_wf
            always_ff @(posedge clk) begin
                if (re) rd <= (we && (wa == ra)) ? wd : mem[ra];
            end
        end else begin : g_rf
            always_ff @(posedge clk) begin
                if (re) rd <= mem[ra];
            end
        end
    endgenerate

endmodule

// File: rtl/tid_inorder_mc.sv
// Multi-channel in-order release buffer: per-channel slot valid/lap tracking, shared RAM,
// round-robin head issue into a 2-entry output FIFO.
module tid_inorder_mc
    import tid_inorder_pkg::*;
#(
    parameter int W   = 32,
    parameter int D   = 16,
    parameter int C   = 4,
    parameter int D_L = $clog2(D),
    parameter int C_L = clog2_min1(C)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_v,
    input  logic [C_L-1:0]        i_ch,
    input  logic [D_L:0]          i_a,
    input  logic [W-1:0]          i_d,
    output logic [C-1:0]          i_f,
    output logic [C*(D_L+1)-1:0]  i_c,
    input  logic                  o_r,
    output logic                  o_v,
    output logic [C_L-1:0]        o_ch,
    output logic [W-1:0]          o_d,
    output logic                  o_err
);

    localparam int AW = C_L + D_L;

    typedef struct packed {
        logic [C_L-1:0] ch;
        logic [W-1:0]   data;
    } ent_t;

    logic [C-1:0][D_L-1:0] head;
    logic [C-1:0]          rdy, gnt, err_hit;
    logic [C_L-1:0]        gnt_idx;
    logic                  gnt_v;

    logic [D_L-1:0]        wr_slot;
    logic                  wr_lap;
    logic                  issue_ok, issue;
    logic                  rd_vld;
    logic [C_L-1:0]        rd_ch;
    logic [W-1:0]          rd_data;

    ent_t                  fifo [FIFO_DEPTH];
    logic                  wp, rp;
    logic [1:0]            fcnt, occ;
    logic                  push, pop;

    assign wr_slot = i_a[D_L-1:0];
    assign wr_lap  = i_a[D_L];

    assign pop  = o_v & o_r;
    assign push = rd_vld;

    // A beat leaving this cycle frees a FIFO entry in time for the read issued now,
    // which is what keeps o_v continuous under o_r=1.
    assign occ      = fcnt + 2'(rd_vld);
    assign issue_ok = (occ < 2'd2) || ((occ == 2'd2) && pop);
    assign issue    = issue_ok & gnt_v;

    generate
        for (genvar c = 0; c < C; c++) begin : g_ch
            logic [D-1:0]   vld_c, lap_c;
            logic [D_L-1:0] head_c;
            logic           exp_lap_c;
            logic [D_L:0]   cnt_c;
            logic           wr_hit, take, dec;

            assign wr_hit = i_v && (i_ch == C_L'(c));
            assign take   = gnt[c] & issue_ok;
            assign dec    = pop && (o_ch == C_L'(c));

            assign rdy[c]     = vld_c[head_c] && (lap_c[head_c] == exp_lap_c);
            assign head[c]    = head_c;
            assign err_hit[c] = wr_hit && vld_c[wr_slot];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_c     <= '0;
                    lap_c     <= '0;
                    head_c    <= '0;
                    exp_lap_c <= 1'b0;
                end else begin
                    // A write to the slot being popped keeps it valid: the new entry survives.
                    for (int s = 0; s < D; s++) begin
                        if (wr_hit && (wr_slot == D_L'(s))) begin
                            vld_c[s] <= 1'b1;
                            lap_c[s] <= wr_lap;
                        end else if (take && (head_c == D_L'(s))) begin
                            vld_c[s] <= 1'b0;
                        end
                    end
                    if (take) begin
                        head_c <= head_c + D_L'(1);
                        if (head_c == D_L'(D - 1)) exp_lap_c <= ~exp_lap_c;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_c <= '0;
                end else if (wr_hit && !dec) begin
                    if (cnt_c != (D_L+1)'(D)) cnt_c <= cnt_c + (D_L+1)'(1);
                end else if (dec && !wr_hit) begin
                    if (cnt_c != '0) cnt_c <= cnt_c - (D_L+1)'(1);
                end
            end

            assign i_f[c]                   = (cnt_c >= (D_L+1)'(D - 1));
            assign i_c[c*(D_L+1) +: (D_L+1)] = cnt_c;
        end
    endgenerate

    rr_arb #(.N(C), .N_L(C_L)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (rdy),
        .adv     (issue_ok),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_v   (gnt_v)
    );

    simple_dual_port_ram #(
        .DW    (W),
        .DEPTH (C * D),
        .AW    (AW),
        .MODE  ("read_first")
    ) u_ram (
        .clk (clk),
        .we  (i_v),
        .wa  ({i_ch, wr_slot}),
        .wd  (i_d),
        .re  (issue),
        .ra  ({gnt_idx, head[gnt_idx]}),
        .rd  (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_ch  <= '0;
            o_err  <= 1'b0;
        end else begin
            rd_vld <= issue;
            if (issue) rd_ch <= gnt_idx;
            o_err  <= |err_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp   <= 1'b0;
            rp   <= 1'b0;
            fcnt <= '0;
        end else begin
            if (push) wp <= ~wp;
            if (pop)  rp <= ~rp;
            fcnt <= fcnt + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wp] <= '{ch: rd_ch, data: rd_data};
    end

    assign o_v  = (fcnt != 2'd0);
    assign o_ch = fifo[rp].ch;
    assign o_d  = fifo[rp].data;

endmodule

// File: tb/tb_tid_inorder_mc.sv
// Directed bench for tid_inorder_mc with C=2, D=4: ordering, RR merge, lap refill, duplicates, stall, reset.
module tb_tid_inorder_mc;

    localparam int W = 32;
    localparam int D = 4;
    localparam int C = 2;

    logic        clk, rst_n;
    logic        i_v;
    logic [0:0]  i_ch;
    logic [2:0]  i_a;
    logic [31:0] i_d;
    logic [1:0]  i_f;
    logic [5:0]  i_c;
    logic        o_r, o_v;
    logic [0:0]  o_ch;
    logic [31:0] o_d;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    tid_inorder_mc #(.W(W), .D(D), .C(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_v   (i_v),
        .i_ch  (i_ch),
        .i_a   (i_a),
        .i_d   (i_d),
        .i_f   (i_f),
        .i_c   (i_c),
        .o_r   (o_r),
        .o_v   (o_v),
        .o_ch  (o_ch),
        .o_d   (o_d),
        .o_err (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input int slot, input int lapb, input logic [31:0] d);
        logic [31:0] s, l, c;
        s    = slot;
        l    = lapb;
        c    = ch;
        i_v  = 1'b1;
        i_ch = c[0];
        i_a  = {l[0], s[1:0]};
        i_d  = d;
        tick();
        i_v  = 1'b0;
    endtask

    task automatic beat(input string tag, input int ch, input logic [31:0] d);
        chk({tag, "_v"}, o_v, 1);
        chk({tag, "_ch"}, o_ch, ch);
        chk({tag, "_d"}, o_d, d);
        tick();
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        i_v   = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_v   = 1'b0;
        i_ch  = '0;
        i_a   = '0;
        i_d   = '0;
        o_r   = 1'b0;
        tick();
        chk("rst_o_v", o_v, 0);
        chk("rst_o_err", o_err, 0);
        chk("rst_i_f", i_f, 0);
        chk("rst_i_c", i_c, 0);
        rst_n = 1'b1;
        tick();

        // Reverse-order writes on ch0 come out in slot order, 2 cycles after slot0 is eligible.
        o_r = 1'b1;
        wr(0, 2, 0, 32'hA000_0002);
        wr(0, 1, 0, 32'hA000_0001);
        wr(0, 0, 0, 32'hA000_0000);
        chk("t1_ov_early0", o_v, 0);
        chk("t1_ic", i_c, 6'b000_011);
        chk("t1_if", i_f, 2'b01);
        tick();
        chk("t1_ov_early1", o_v, 0);
        tick();
        beat("t1_b0", 0, 32'hA000_0000);
        beat("t1_b1", 0, 32'hA000_0001);
        beat("t1_b2", 0, 32'hA000_0002);
        chk("t1_ov_end", o_v, 0);
        chk("t1_ic_end", i_c, 0);
        chk("t1_err", o_err, 0);

        // Two channels with three ready heads each alternate through the arbiter.
        do_reset();
        tick();
        o_r = 1'b1;
        wr(0, 2, 0, 32'hB000_0002);
        wr(0, 1, 0, 32'hB000_0001);
        wr(1, 2, 0, 32'hB100_0002);
        wr(1, 1, 0, 32'hB100_0001);
        wr(0, 0, 0, 32'hB000_0000);
        wr(1, 0, 0, 32'hB100_0000);
        chk("t2_ov_early", o_v, 0);
        tick();
        beat("t2_b0", 0, 32'hB000_0000);
        beat("t2_b1", 1, 32'hB100_0000);
        beat("t2_b2", 0, 32'hB000_0001);
        beat("t2_b3", 1, 32'hB100_0001);
        beat("t2_b4", 0, 32'hB000_0002);
        beat("t2_b5", 1, 32'hB100_0002);
        chk("t2_ov_end", o_v, 0);

        // Lap refill of slot0 while slots 2,3 are still pending.
        do_reset();
        tick();
        o_r = 1'b0;
        wr(0, 0, 0, 32'hC000_0000);
        wr(0, 1, 0, 32'hC000_0001);
        wr(0, 2, 0, 32'hC000_0002);
        wr(0, 3, 0, 32'hC000_0003);
        chk("t3_ic_full", i_c, 6'b000_100);
        chk("t3_if_full", i_f, 2'b01);
        o_r = 1'b1;
        beat("t3_b0", 0, 32'hC000_0000);
        beat("t3_b1", 0, 32'hC000_0001);
        o_r = 1'b0;
        chk("t3_hold_v", o_v, 1);
        chk("t3_hold_d", o_d, 32'hC000_0002);
        wr(0, 0, 1, 32'hC100_0000);
        chk("t3_no_err", o_err, 0);
        chk("t3_ic_refill", i_c, 6'b000_011);
        o_r = 1'b1;
        beat("t3_b2", 0, 32'hC000_0002);
        beat("t3_b3", 0, 32'hC000_0003);
        beat("t3_b4", 0, 32'hC100_0000);
        chk("t3_ov_end", o_v, 0);
        chk("t3_ic_end", i_c, 0);

        // Early next-lap write must not release; duplicate tid on ch1 flags o_err once.
        do_reset();
        tick();
        o_r = 1'b1;
        wr(0, 0, 1, 32'hDEAD_0000);
        wr(1, 1, 0, 32'hD100_0001);
        chk("t4_err_first", o_err, 0);
        wr(1, 1, 0, 32'hD100_0011);
        chk("t4_err_pulse", o_err, 1);
        chk("t4_ic_dup", i_c, 6'b010_001);
        wr(1, 0, 0, 32'hD100_0000);
        chk("t4_err_clear", o_err, 0);
        chk("t4_ov_early0", o_v, 0);
        tick();
        chk("t4_ov_early1", o_v, 0);
        tick();
        beat("t4_b0", 1, 32'hD100_0000);
        beat("t4_b1", 1, 32'hD100_0011);
        chk("t4_ov_end", o_v, 0);
        chk("t4_ic_end", i_c, 6'b001_001);
        tick();
        chk("t4_no_lap_release", o_v, 0);

        // Stall with four ready entries: head beat holds, then all drain in order.
        do_reset();
        tick();
        o_r = 1'b0;
        wr(0, 0, 0, 32'hE000_0000);
        wr(0, 1, 0, 32'hE000_0001);
        wr(0, 2, 0, 32'hE000_0002);
        wr(0, 3, 0, 32'hE000_0003);
        for (int k = 0; k < 10; k++) begin
            chk("t5_stall_v", o_v, 1);
            chk("t5_stall_d", o_d, 32'hE000_0000);
            tick();
        end
        o_r = 1'b1;
        beat("t5_b0", 0, 32'hE000_0000);
        beat("t5_b1", 0, 32'hE000_0001);
        beat("t5_b2", 0, 32'hE000_0002);
        beat("t5_b3", 0, 32'hE000_0003);
        chk("t5_ov_end", o_v, 0);
        chk("t5_ic_end", i_c, 0);

        // Asynchronous reset while a beat is presented.
        do_reset();
        tick();
        o_r = 1'b0;
        wr(0, 0, 0, 32'hF000_0000);
        wr(0, 1, 0, 32'hF000_0001);
        wr(0, 2, 0, 32'hF000_0002);
        chk("t6_pre_v", o_v, 1);
        chk("t6_pre_ic", i_c, 6'b000_011);
        rst_n = 1'b0;
        #1;
        chk("t6_async_v", o_v, 0);
        chk("t6_async_ic", i_c, 0);
        chk("t6_async_if", i_f, 0);
        chk("t6_async_err", o_err, 0);
        #2;
        rst_n = 1'b1;
        tick();
        o_r = 1'b1;
        wr(0, 0, 0, 32'hF100_0000);
        chk("t6_post_early0", o_v, 0);
        tick();
        chk("t6_post_early1", o_v, 0);
        tick();
        beat("t6_b0", 0, 32'hF100_0000);
        chk("t6_ov_end", o_v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
